// File: rtl/display_buffer_pkg.sv
// Display buffer shared definitions: frame geometry defaults, writer FSM
// state encoding and the raster address helper used by the VGA reader.
package display_buffer_pkg;

  localparam int unsigned DEF_IMG_W  = 62;
  localparam int unsigned DEF_IMG_H  = 82;
  localparam int unsigned DEF_ADDR_W = 13;
  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned FRAME_PIX  = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

  // Raster address of a pixel: row*IMG_W + col.
  function automatic int unsigned pix_addr(input int unsigned row, input int unsigned col);
    return row * DEF_IMG_W + col;
  endfunction

endpackage

// File: rtl/display_buffer_writer_if.sv
// Display buffer bus: stage-5 pixel stream (valid/ready) plus the
// display read port scanned by the VGA front end.
interface display_buffer_writer_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned PIX_W  = 8
);
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic              in_ready;
  logic              ena_display;
  logic              read_display;
  logic [ADDR_W-1:0] addr_display;
  logic              dout_display;

  modport master (
    output in_valid, in_pixel, ena_display, read_display, addr_display,
    input  in_ready, dout_display
  );

  modport slave (
    input  in_valid, in_pixel, ena_display, read_display, addr_display,
    output in_ready, dout_display
  );
endinterface

// File: rtl/disp_bram_1b.sv
// Simple dual-port 1-bit RAM, read-first, registered read port.
// Addresses at or beyond DEPTH read back 0 and are never written.
module disp_bram_1b #(
  parameter int unsigned DEPTH  = 5084,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);

  logic r_mem [DEPTH];
  logic r_rdata;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_W'(DEPTH))) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read; samples pre-edge contents so a same-address write returns the old bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 1'b0;
    end else if (re) begin
      if (raddr < ADDR_W'(DEPTH)) begin
        r_rdata <= r_mem[raddr];
      end else begin
        r_rdata <= 1'b0;
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/display_buffer_writer.sv
// Write side of the CNN result display buffer: binarises the stage-5 pixel
// stream and stores one frame in raster order; serves the display read port.
// Optional macro DISP_THRESH_EN: adds the thresh port and stores
// (in_pixel >= thresh); otherwise the pixel MSB is stored.
module display_buffer_writer
  import display_buffer_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PIX_W  = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
`ifdef DISP_THRESH_EN
  input  logic [PIX_W-1:0]         thresh,
`endif
  display_buffer_writer_if.slave   bus,
  output logic                     done,
  output logic                     busy
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  wr_state_t         r_state;
  logic              r_in_ready;
  logic              r_done;
  logic              r_busy;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_wr_addr;

  logic w_accept;
  logic w_last;
  logic w_bit;
  logic w_rd_en;
  logic w_rdata;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_last   = (r_col == COL_W'(IMG_W - 1)) && (r_row == ROW_W'(IMG_H - 1));
  assign w_rd_en  = bus.ena_display && bus.read_display;

`ifdef DISP_THRESH_EN
  assign w_bit = (bus.in_pixel >= thresh);
`else
  logic w_unused_pix_lsbs;
  assign w_bit             = bus.in_pixel[PIX_W-1];
  assign w_unused_pix_lsbs = ^bus.in_pixel[PIX_W-2:0];
`endif

  // Frame-store FSM with raster counters and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_wr_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            r_state    <= ST_WRITE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_wr_addr  <= '0;
          end
        end
        ST_WRITE: begin
          if (w_accept) begin
            // Counters stay parked on the last pixel so they never pass NPIX-1.
            if (w_last) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_wr_addr <= r_wr_addr + 1'b1;
              if (r_col == COL_W'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  disp_bram_1b #(
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_accept),
    .waddr (r_wr_addr),
    .wdata (w_bit),
    .re    (w_rd_en),
    .raddr (bus.addr_display),
    .rdata (w_rdata)
  );

  assign bus.in_ready     = r_in_ready;
  assign bus.dout_display = w_rdata;
  assign done             = r_done;
  assign busy             = r_busy;

endmodule
